// File: rtl/red_pitaya_asg_sweep.sv
// Frequency-sweep controller driving one ASG channel's phase-step input.
// Optional trigger-driven advancement is compiled in with ASG_SWEEP_TRIG_EN.
module red_pitaya_asg_sweep #(
  parameter int SW = 32,
  parameter int DW = 32
) (
  input  logic          dac_clk_i,
  input  logic          dac_rst_i,
  input  logic [SW-1:0] cfg_start_i,
  input  logic [SW-1:0] cfg_stop_i,
  input  logic [SW-1:0] cfg_inc_i,
  input  logic [DW-1:0] cfg_dwell_i,
  input  logic [1:0]    cfg_mode_i,
  input  logic          ctl_start_i,
  input  logic          ctl_abort_i,
`ifdef ASG_SWEEP_TRIG_EN
  input  logic          trig_i,
  input  logic          cfg_trig_adv_i,
`endif
  output logic [SW-1:0] step_o,
  output logic          step_upd_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [15:0]   pass_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;

  state_t        state_q, state_d;
  logic [SW-1:0] start_q, stop_q, inc_q, tgt_q, step_q;
  logic [DW-1:0] dwell_q, cnt_q, dwell_ld;
  logic [1:0]    mode_q;
  logic [15:0]   pass_q;
  logic          upd_q, done_q, advance, at_tgt, single;
  logic [SW-1:0] other_end;

  // Move cur one increment toward tgt, clamping on overshoot or wrap.
  function automatic logic [SW-1:0] step_toward(input logic [SW-1:0] cur, tgt, inc);
    logic [SW:0]   sum;
    logic [SW-1:0] res;
    if (tgt >= cur) begin
      sum = {1'b0, cur} + {1'b0, inc};
      res = (sum[SW] || sum[SW-1:0] > tgt) ? tgt : sum[SW-1:0];
    end else begin
      sum = {1'b0, cur} - {1'b0, inc};
      res = (sum[SW] || sum[SW-1:0] < tgt) ? tgt : sum[SW-1:0];
    end
    return res;
  endfunction

  assign dwell_ld  = (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - 1'b1;
  assign at_tgt    = (step_q == tgt_q);
  assign single    = (mode_q != MODE_SAW) && (mode_q != MODE_TRI);
  assign other_end = (tgt_q == stop_q) ? start_q : stop_q;

`ifdef ASG_SWEEP_TRIG_EN
  logic trig_adv_q;
  assign advance = (state_q == RUN) && (trig_adv_q ? trig_i : (cnt_q == '0));
`else
  assign advance = (state_q == RUN) && (cnt_q == '0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (ctl_abort_i)                          state_d = IDLE;
    else if (ctl_start_i)                     state_d = RUN;
    else if (advance && at_tgt && single)     state_d = DONE;
  end

  always_comb begin
    busy_o = (state_q == RUN);
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      pass_q  <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef ASG_SWEEP_TRIG_EN
      trig_adv_q <= 1'b0;
`endif
    end else begin
      upd_q <= 1'b0;
      if (ctl_abort_i) begin
        // Abort freezes the step value and the done flag.
      end else if (ctl_start_i) begin
        start_q <= cfg_start_i;
        stop_q  <= cfg_stop_i;
        inc_q   <= cfg_inc_i;
        mode_q  <= cfg_mode_i;
        dwell_q <= dwell_ld;
        cnt_q   <= dwell_ld;
        tgt_q   <= cfg_stop_i;
        step_q  <= cfg_start_i;
        upd_q   <= 1'b1;
        done_q  <= 1'b0;
        pass_q  <= '0;
`ifdef ASG_SWEEP_TRIG_EN
        trig_adv_q <= cfg_trig_adv_i;
`endif
      end else if (state_q == RUN) begin
        if (advance) begin
          cnt_q <= dwell_q;
          if (!at_tgt) begin
            step_q <= step_toward(step_q, tgt_q, inc_q);
            upd_q  <= 1'b1;
          end else begin
            if (pass_q != 16'hffff) pass_q <= pass_q + 1'b1;
            if (mode_q == MODE_SAW) begin
              step_q <= start_q;
              upd_q  <= 1'b1;
            end else if (mode_q == MODE_TRI) begin
              tgt_q  <= other_end;
              step_q <= step_toward(step_q, other_end, inc_q);
              upd_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign step_o     = step_q;
  assign step_upd_o = upd_q;
  assign done_o     = done_q;
  assign pass_cnt_o = pass_q;

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Self-checking bench for red_pitaya_asg_sweep: table-driven sweeps plus
// hand-written abort, reset and (with ASG_SWEEP_TRIG_EN) trigger sequences.
module tb_red_pitaya_asg_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_start, cfg_stop, cfg_inc, cfg_dwell;
  logic [1:0]  cfg_mode;
  logic        ctl_start, ctl_abort;
  logic [31:0] step;
  logic        step_upd, busy, done;
  logic [15:0] pass_cnt;
`ifdef ASG_SWEEP_TRIG_EN
  logic        trig, cfg_trig_adv;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  red_pitaya_asg_sweep #(.SW(32), .DW(32)) dut (
    .dac_clk_i   (clk),
    .dac_rst_i   (rst),
    .cfg_start_i (cfg_start),
    .cfg_stop_i  (cfg_stop),
    .cfg_inc_i   (cfg_inc),
    .cfg_dwell_i (cfg_dwell),
    .cfg_mode_i  (cfg_mode),
    .ctl_start_i (ctl_start),
    .ctl_abort_i (ctl_abort),
`ifdef ASG_SWEEP_TRIG_EN
    .trig_i         (trig),
    .cfg_trig_adv_i (cfg_trig_adv),
`endif
    .step_o      (step),
    .step_upd_o  (step_upd),
    .busy_o      (busy),
    .done_o      (done),
    .pass_cnt_o  (pass_cnt)
  );

  typedef struct packed {
    logic [1:0]        mode;
    logic [31:0]       start;
    logic [31:0]       stop;
    logic [31:0]       inc;
    logic [31:0]       dwell;
    logic [0:11][31:0] seq;
    logic              busy;
    logic              done;
    logic [15:0]       pass;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [31:0] s, e, i, d);
    cfg_mode = m; cfg_start = s; cfg_stop = e; cfg_inc = i; cfg_dwell = d;
  endtask

  // Leaves the bench at the negedge where the first swept value is visible.
  task automatic pulse_start();
    @(negedge clk) ctl_start = 1'b1;
    @(negedge clk) ctl_start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk) ctl_abort = 1'b1;
    @(negedge clk) ctl_abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctl_start = 1'b0; ctl_abort = 1'b0;
    set_cfg(2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
`ifdef ASG_SWEEP_TRIG_EN
    trig = 1'b0; cfg_trig_adv = 1'b0;
`endif

    vecs[0] = '{mode:2'd0, start:32'd100, stop:32'd130, inc:32'd10, dwell:32'd3,
                seq:'{100,100,100,110,110,110,120,120,120,130,130,130}, busy:1'b0, done:1'b1, pass:16'd1};
    vecs[1] = '{mode:2'd0, start:32'd50, stop:32'd20, inc:32'd12, dwell:32'd1,
                seq:'{50,38,26,20,20,20,20,20,20,20,20,20}, busy:1'b0, done:1'b1, pass:16'd1};
    vecs[2] = '{mode:2'd2, start:32'd0, stop:32'd4, inc:32'd2, dwell:32'd1,
                seq:'{0,2,4,2,0,2,4,2,0,2,4,2}, busy:1'b1, done:1'b0, pass:16'd5};
    vecs[3] = '{mode:2'd1, start:32'd5, stop:32'd7, inc:32'd1, dwell:32'd2,
                seq:'{5,5,6,6,7,7,5,5,6,6,7,7}, busy:1'b1, done:1'b0, pass:16'd2};
    vecs[4] = '{mode:2'd0, start:32'd9, stop:32'd9, inc:32'd3, dwell:32'd2,
                seq:'{9,9,9,9,9,9,9,9,9,9,9,9}, busy:1'b0, done:1'b1, pass:16'd1};
    vecs[5] = '{mode:2'd1, start:32'd3, stop:32'd8, inc:32'd0, dwell:32'd0,
                seq:'{3,3,3,3,3,3,3,3,3,3,3,3}, busy:1'b1, done:1'b0, pass:16'd0};
    vecs[6] = '{mode:2'd0, start:32'hffff_fff0, stop:32'hffff_ffff, inc:32'd8, dwell:32'd1,
                seq:'{32'hffff_fff0, 32'hffff_fff8, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff,
                      32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff},
                busy:1'b0, done:1'b1, pass:16'd1};
    vecs[7] = '{mode:2'd3, start:32'd10, stop:32'd12, inc:32'd1, dwell:32'd4,
                seq:'{10,10,10,10,11,11,11,11,12,12,12,12}, busy:1'b0, done:1'b1, pass:16'd1};

    #12;
    check("reset step", step, 0);
    check("reset upd", step_upd, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass_cnt, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_cfg(vecs[i].mode, vecs[i].start, vecs[i].stop, vecs[i].inc, vecs[i].dwell);
      pulse_start();
      // Scribble on the config: the running sweep must ignore it.
      set_cfg(2'd1, 32'h1234_5678, 32'h0000_0001, 32'h0777_0000, 32'd5);
      check($sformatf("v%0d first upd", i), step_upd, 1);
      check($sformatf("v%0d first busy", i), busy, 1);
      for (int k = 0; k < 12; k++) begin
        check($sformatf("v%0d step[%0d]", i, k), step, vecs[i].seq[k]);
        @(negedge clk);
      end
      check($sformatf("v%0d busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d done", i), done, vecs[i].done);
      check($sformatf("v%0d pass", i), pass_cnt, vecs[i].pass);
      if (vecs[i].done) check($sformatf("v%0d no upd at done", i), step_upd, 0);
      pulse_abort();
      check($sformatf("v%0d abort busy", i), busy, 0);
      check($sformatf("v%0d abort keeps done", i), done, vecs[i].done);
    end

    // Sawtooth with abort: step_upd only on value changes, step frozen after abort.
    set_cfg(2'd1, 32'd5, 32'd7, 32'd1, 32'd2);
    pulse_start();
    @(negedge clk) check("saw upd hold cycle", step_upd, 0);
    @(negedge clk) check("saw upd second value", step_upd, 1);
    check("saw second value", step, 6);
    @(negedge clk);
    @(negedge clk);
    check("saw at stop", step, 7);
    ctl_abort = 1'b1;
    @(negedge clk) ctl_abort = 1'b0;
    check("abort busy next cycle", busy, 0);
    check("abort step frozen", step, 7);
    @(negedge clk) check("abort step still frozen", step, 7);
    check("abort done unchanged", done, 0);

    // Start and abort together while idle: abort wins.
    @(negedge clk) begin ctl_start = 1'b1; ctl_abort = 1'b1; end
    @(negedge clk) begin ctl_start = 1'b0; ctl_abort = 1'b0; end
    check("start+abort busy", busy, 0);
    check("start+abort step", step, 7);

    // Restart while running clears the pass count and reloads start.
    set_cfg(2'd2, 32'd0, 32'd4, 32'd2, 32'd1);
    pulse_start();
    repeat (6) @(negedge clk);
    check("tri pass before restart", pass_cnt, 2);
    set_cfg(2'd0, 32'd40, 32'd50, 32'd5, 32'd1);
    pulse_start();
    check("restart step", step, 40);
    check("restart pass cleared", pass_cnt, 0);
    check("restart busy", busy, 1);

    // Asynchronous reset mid-sweep.
    #2 rst = 1'b1;
    #1;
    check("async rst step", step, 0);
    check("async rst busy", busy, 0);
    check("async rst upd", step_upd, 0);
    check("async rst done", done, 0);
    check("async rst pass", pass_cnt, 0);
    @(negedge clk) rst = 1'b0;

`ifdef ASG_SWEEP_TRIG_EN
    begin
      int upd_seen;
      upd_seen = 0;
      set_cfg(2'd0, 32'd0, 32'd100, 32'd1, 32'd1000);
      cfg_trig_adv = 1'b1;
      @(negedge clk) begin ctl_start = 1'b1; trig = 1'b1; end
      @(negedge clk) begin ctl_start = 1'b0; trig = 1'b0; end
      cfg_trig_adv = 1'b0;
      check("trig start value", step, 0);
      repeat (5) @(negedge clk);
      check("trig no dwell advance", step, 0);
      for (int p = 0; p < 3; p++) begin
        @(negedge clk) trig = 1'b1;
        @(negedge clk) begin trig = 1'b0; if (step_upd) upd_seen++; end
        repeat (3) @(negedge clk) if (step_upd) upd_seen++;
      end
      check("trig step after 3 pulses", step, 3);
      check("trig upd count", upd_seen, 3);
      pulse_abort();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
